// File: rtl/sh_mac_unit_if.sv
// CPU-side data/control bundle for the SH multiply/accumulate unit.
// The CPU drives op/sel/we/sat_s/a1/di; the MAC unit returns dout and busy.
interface sh_mac_unit_if;
   logic [3:0]  op;
   logic [1:0]  sel;
   logic        we;
   logic        sat_s;
   logic        a1;
   logic [31:0] di;
   logic [31:0] dout;
   logic        busy;

   modport master (output op, sel, we, sat_s, a1, di, input dout, busy);
   modport slave  (input op, sel, we, sat_s, a1, di, output dout, busy);
endinterface

// File: rtl/sh_mac_unit.sv
// SH1/SH2 multiply/accumulate unit: MACH/MACL registers plus an iterative 16x16 multiplier.
// .W ops take one multiply step and .L ops take four, each followed by one write-back cycle.
module sh_mac_unit #(
   parameter int unsigned MachW   = 10,
   parameter bit          HasLong = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          ce_r_i,
   sh_mac_unit_if.slave  mac_io
);

   localparam int unsigned AccW = MachW + 32;
   localparam logic signed [65:0] SatMax = 66'sh0_7FFF_FFFF_FFFF;
   localparam logic signed [65:0] SatMin = -66'sh8000_0000_0000;

   typedef enum logic [1:0] {StIdle, StMul, StWb} state_e;
   typedef enum logic [2:0] {KNone, KLds, KClr, KMulW, KMulL, KDmul, KMacW, KMacL} kind_e;

   function automatic kind_e decode(input logic [3:0] op);
      kind_e k;
      case (op)
         4'b0100, 4'b1000: k = KLds;
         4'b1111:          k = KClr;
         4'b0110, 4'b0111: k = KMulW;
         4'b1011:          k = KMacW;
         4'b0001:          k = HasLong ? KMulL : KNone;
         4'b0010, 4'b0011: k = HasLong ? KDmul : KNone;
         4'b1001:          k = (HasLong && MachW == 32) ? KMacL : KNone;
         default:          k = KNone;
      endcase
      return k;
   endfunction

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic              sgn_q, sgn_d;
   logic              sat_q, sat_d;
   logic [1:0]        step_q, step_d;
   logic [63:0]       prod_q, prod_d;
   logic [31:0]       ma_q, ma_d;
   logic [31:0]       mb_q, mb_d;
   logic [MachW-1:0]  mach_q, mach_d;
   logic [31:0]       macl_q, macl_d;

   kind_e             kind_in;
   logic              sgn_in;
   logic              accept;
   logic              start;
   logic [15:0]       half_in;

   assign kind_in = decode(mac_io.op);
   assign sgn_in  = (mac_io.op == 4'b0111) || (mac_io.op == 4'b0011) ||
                    (mac_io.op == 4'b1011) || (mac_io.op == 4'b1001);
   assign accept  = mac_io.we && ce_r_i && (|mac_io.sel) && (state_q == StIdle);
   assign half_in = mac_io.a1 ? mac_io.di[15:0] : mac_io.di[31:16];

   // Partial-product datapath. Halves are widened to 17 bits: a half is sign-extended only
   // when it is the top half of a signed operand, so the four partials sum to the exact
   // two's-complement product.
   logic              is_w_q;
   logic              a_hi, b_hi;
   logic [15:0]       a_half, b_half;
   logic signed [16:0] pa, pb;
   logic signed [33:0] pp;
   logic [5:0]        pp_shift;
   logic [63:0]       pp_sh;
   logic              last_step;

   assign is_w_q    = (kind_q == KMulW) || (kind_q == KMacW);
   assign a_hi      = !is_w_q && step_q[0];
   assign b_hi      = !is_w_q && step_q[1];
   assign a_half    = a_hi ? ma_q[31:16] : ma_q[15:0];
   assign b_half    = b_hi ? mb_q[31:16] : mb_q[15:0];
   assign pa        = $signed({sgn_q && (is_w_q || a_hi) && a_half[15], a_half});
   assign pb        = $signed({sgn_q && (is_w_q || b_hi) && b_half[15], b_half});
   assign pp        = pa * pb;
   assign last_step = is_w_q || (step_q == 2'd3);

   always_comb begin
      pp_shift = 6'd0;
      case (step_q)
         2'd1, 2'd2: pp_shift = 6'd16;
         2'd3:       pp_shift = 6'd32;
         default:    pp_shift = 6'd0;
      endcase
   end

   assign pp_sh = 64'(pp) << pp_shift;

   // Accumulate paths for write-back.
   logic [AccW-1:0]    macw_acc;
   logic signed [32:0] macw_sum;
   logic               macw_ovf;
   logic signed [63:0] mac64;
   logic signed [65:0] macl_sum;
   logic [63:0]        macl_res;

   assign macw_acc = {mach_q, macl_q} + AccW'($signed(prod_q[31:0]));
   assign macw_sum = $signed({macl_q[31], macl_q}) + $signed({prod_q[31], prod_q[31:0]});
   assign macw_ovf = macw_sum[32] ^ macw_sum[31];
   assign mac64    = 64'($signed({mach_q, macl_q}));
   assign macl_sum = 66'(mac64) + 66'($signed(prod_q));

   always_comb begin
      macl_res = macl_sum[63:0];
      if (sat_q) begin
         if (macl_sum > SatMax) begin
            macl_res = SatMax[63:0];
         end else if (macl_sum < SatMin) begin
            macl_res = SatMin[63:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      sgn_d   = sgn_q;
      sat_d   = sat_q;
      step_d  = step_q;
      prod_d  = prod_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      mach_d  = mach_q;
      macl_d  = macl_q;
      start   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               case (kind_in)
                  KLds: begin
                     if (mac_io.sel[0]) macl_d = mac_io.di;
                     if (mac_io.sel[1]) mach_d = mac_io.di[MachW-1:0];
                  end
                  KClr: begin
                     mach_d = '0;
                     macl_d = '0;
                  end
                  KMulW: begin
                     if (mac_io.sel[1]) begin
                        ma_d  = {16'h0, mac_io.di[15:0]};
                        mb_d  = {16'h0, mac_io.di[31:16]};
                        start = 1'b1;
                     end
                  end
                  KMacW: begin
                     if (mac_io.sel == 2'b01) begin
                        ma_d = {16'h0, half_in};
                     end else if (mac_io.sel == 2'b10) begin
                        mb_d  = {16'h0, half_in};
                        start = 1'b1;
                     end
                  end
                  KMulL, KDmul, KMacL: begin
                     if (mac_io.sel == 2'b01) begin
                        ma_d = mac_io.di;
                     end else if (mac_io.sel == 2'b10) begin
                        mb_d  = mac_io.di;
                        start = 1'b1;
                     end
                  end
                  default: ;
               endcase
               if (start) begin
                  state_d = StMul;
                  kind_d  = kind_in;
                  sgn_d   = sgn_in;
                  sat_d   = mac_io.sat_s;
                  step_d  = 2'd0;
                  prod_d  = '0;
               end
            end
         end
         StMul: begin
            prod_d = prod_q + pp_sh;
            step_d = step_q + 2'd1;
            if (last_step) state_d = StWb;
         end
         StWb: begin
            state_d = StIdle;
            case (kind_q)
               KMulW, KMulL: macl_d = prod_q[31:0];
               KDmul: begin
                  mach_d = prod_q[32 +: MachW];
                  macl_d = prod_q[31:0];
               end
               KMacW: begin
                  if (!sat_q) begin
                     {mach_d, macl_d} = macw_acc;
                  end else if (macw_ovf) begin
                     macl_d = macw_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                     if (MachW == 32) mach_d[0] = 1'b1;
                  end else begin
                     macl_d = macw_sum[31:0];
                  end
               end
               KMacL: begin
                  mach_d = macl_res[32 +: MachW];
                  macl_d = macl_res[31:0];
               end
               default: ;
            endcase
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         kind_q  <= KNone;
         sgn_q   <= 1'b0;
         sat_q   <= 1'b0;
         step_q  <= 2'd0;
         prod_q  <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         mach_q  <= '0;
         macl_q  <= '0;
      end else if (ce_r_i) begin
         state_q <= state_d;
         kind_q  <= kind_d;
         sgn_q   <= sgn_d;
         sat_q   <= sat_d;
         step_q  <= step_d;
         prod_q  <= prod_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         mach_q  <= mach_d;
         macl_q  <= macl_d;
      end
   end

   assign mac_io.busy = (state_q != StIdle);
   assign mac_io.dout = mac_io.sel[1] ? 32'($signed(mach_q)) : macl_q;

endmodule
